// File: rtl/uart_pkg.sv
// Shared types for the configurable UART transmitter: FSM state encoding,
// parity-type constants and the parity helper used when a word is latched.
// Latency: n/a (types and a pure function). Backpressure: n/a.
package uart_pkg;

   // Transmit FSM states; busy is simply "not IDLE".
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_e;

   // Parity type selector values (PAR_TYP input).
   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   // Widest frame payload supported; narrower words are zero-extended,
   // which leaves the XOR reduction unchanged.
   localparam int MAX_DATA_WD = 9;

   // Parity bit for a data word: even -> ^data, odd -> ~^data.
   function automatic logic calc_parity(input logic [MAX_DATA_WD-1:0] data,
                                        input logic                   par_typ);
      logic p;
      case (par_typ)
         PAR_EVEN: p = ^data;
         PAR_ODD:  p = ~^data;
         default:  p = ^data;
      endcase
      return p;
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Generic synchronous FIFO (no bypass) buffering words ahead of the serialiser.
// Latency: a pushed word is visible at the head (empty_o low) from the next edge.
// Backpressure: full_o is registered; pushes while full and pops while empty are ignored.
//
// Ports:
//   clk_i, rst_ni       clock, synchronous active-low reset
//   push_i, wdata_i     write strobe and data
//   pop_i, rdata_o      read strobe and head-of-queue data (combinational read)
//   full_o, empty_o     registered status flags
//   count_o             current occupancy, 0..DEPTH
module uart_tx_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int PTR_WD = $clog2(DEPTH);
   localparam int CNT_WD = PTR_WD + 1;

   logic [WIDTH-1:0]  mem_q [DEPTH];
   logic [PTR_WD-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_WD-1:0] count_q, count_d;
   logic              full_q, empty_q;
   logic              push_ok, pop_ok;

   assign push_ok = push_i & ~full_q;
   assign pop_ok  = pop_i  & ~empty_q;

   // Simultaneous push and pop leaves the occupancy unchanged.
   always_comb begin
      count_d = count_q;
      if (push_ok && !pop_ok) begin
         count_d = count_q + CNT_WD'(1);
      end else if (!push_ok && pop_ok) begin
         count_d = count_q - CNT_WD'(1);
      end
   end

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         if (push_ok) begin
            wr_ptr_q <= wr_ptr_q + PTR_WD'(1);
         end
         if (pop_ok) begin
            rd_ptr_q <= rd_ptr_q + PTR_WD'(1);
         end
         count_q <= count_d;
         full_q  <= (count_d == CNT_WD'(DEPTH));
         empty_q <= (count_d == '0);
      end
   end

   // Storage carries no reset: stale entries are unreachable once the
   // pointers are cleared.
   always_ff @(posedge clk_i) begin
      if (rst_ni && push_ok) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign full_o  = full_q;
   assign empty_o = empty_q;
   assign count_o = count_q;

endmodule

// File: rtl/uart_tx_cfg.sv
// FIFO-buffered UART transmitter: LSB-first words, optional parity, 1/2 stop bits, runtime baud divisor.
// Latency: word pushed into an empty FIFO while idle starts its START bit one clock later; frames run back-to-back.
// Backpressure: Data_Ready = !full (registered flag); the producer holds Data_Valid until accepted.
//
// Ports:
//   CLK, RST            clock, synchronous active-low reset
//   P_DATA, Data_Valid  word offered by the producer
//   Data_Ready          FIFO can take a word this cycle
//   PAR_EN, PAR_TYP     parity enable, parity type (0 even, 1 odd)
//   STOP2               two stop bits when high
//   BAUD_DIV            clocks per bit (0 behaves as 1)
//   TX_OUT              registered serial line, idles high
//   busy                FSM not in IDLE
//   fifo_count          FIFO occupancy
module uart_tx_cfg #(
   parameter int DATA_WD = 8,
   parameter int DEPTH   = 4,
   parameter int DIV_WD  = 16
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic [DATA_WD-1:0]       P_DATA,
   input  logic                     Data_Valid,
   output logic                     Data_Ready,
   input  logic                     PAR_EN,
   input  logic                     PAR_TYP,
   input  logic                     STOP2,
   input  logic [DIV_WD-1:0]        BAUD_DIV,
   output logic                     TX_OUT,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   fifo_count
);

   import uart_pkg::*;

   localparam int                IDX_WD   = $clog2(DATA_WD);
   localparam logic [IDX_WD-1:0] LAST_IDX = IDX_WD'(DATA_WD - 1);

   // FIFO interface
   logic [DATA_WD-1:0] fifo_rdata;
   logic               fifo_full;
   logic               fifo_empty;
   logic               fifo_pop;

   // FSM and timing state
   tx_state_e          state_q, state_d;
   logic [DIV_WD-1:0]  cnt_q, cnt_d;
   logic [IDX_WD-1:0]  idx_q, idx_d;
   logic [IDX_WD-1:0]  nxt_idx;
   logic               tx_q, tx_d;
   logic               bit_end;

   // Per-frame configuration, captured when the word leaves the FIFO
   logic [DATA_WD-1:0] data_q;
   logic               par_q;
   logic               par_en_q;
   logic               stop2_q;
   logic [DIV_WD-1:0]  div_m1_q;

   // Values captured at pop time
   logic [DIV_WD-1:0]  baud_m1;
   logic               head_par;

   uart_tx_fifo #(
      .WIDTH (DATA_WD),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i   (CLK),
      .rst_ni  (RST),
      .push_i  (Data_Valid),
      .wdata_i (P_DATA),
      .pop_i   (fifo_pop),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   assign Data_Ready = ~fifo_full;

   // The bit counter holds "clocks remaining minus one", so a divisor of
   // 0 or 1 both load 0 and every clock is a bit boundary.
   assign baud_m1  = (BAUD_DIV == '0) ? '0 : BAUD_DIV - DIV_WD'(1);
   assign head_par = calc_parity(MAX_DATA_WD'(fifo_rdata), PAR_TYP);

   assign bit_end = (cnt_q == '0);
   assign nxt_idx = idx_q + IDX_WD'(1);

   // Next-state logic. tx_d is the line level for the bit that starts at
   // the coming edge, so TX_OUT changes exactly on bit boundaries.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      tx_d     = tx_q;
      fifo_pop = 1'b0;

      if (state_q != IDLE) begin
         cnt_d = bit_end ? div_m1_q : cnt_q - DIV_WD'(1);
      end

      case (state_q)
         IDLE: begin
            tx_d     = 1'b1;
            fifo_pop = ~fifo_empty;
         end
         START: begin
            if (bit_end) begin
               state_d = DATA;
               idx_d   = '0;
               tx_d    = data_q[0];
            end
         end
         DATA: begin
            if (bit_end) begin
               if (idx_q == LAST_IDX) begin
                  idx_d = '0;
                  if (par_en_q) begin
                     state_d = PARITY;
                     tx_d    = par_q;
                  end else begin
                     state_d = STOP;
                     tx_d    = 1'b1;
                  end
               end else begin
                  idx_d = nxt_idx;
                  tx_d  = data_q[nxt_idx];
               end
            end
         end
         PARITY: begin
            if (bit_end) begin
               state_d = STOP;
               tx_d    = 1'b1;
            end
         end
         STOP: begin
            // idx_q counts stop bits: 0 = first, 1 = second.
            if (bit_end) begin
               if (stop2_q && (idx_q == '0)) begin
                  idx_d = IDX_WD'(1);
                  tx_d  = 1'b1;
               end else if (!fifo_empty) begin
                  fifo_pop = 1'b1;
               end else begin
                  state_d = IDLE;
                  tx_d    = 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            tx_d    = 1'b1;
         end
      endcase

      // A pop always launches a new frame on the same edge, giving
      // back-to-back frames with no idle bit between them.
      if (fifo_pop) begin
         state_d = START;
         tx_d    = 1'b0;
         cnt_d   = baud_m1;
         idx_d   = '0;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         idx_q    <= '0;
         tx_q     <= 1'b1;
         data_q   <= '0;
         par_q    <= 1'b0;
         par_en_q <= 1'b0;
         stop2_q  <= 1'b0;
         div_m1_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         tx_q    <= tx_d;
         // Config inputs are only sampled here, so mid-frame changes
         // apply from the next frame onward.
         if (fifo_pop) begin
            data_q   <= fifo_rdata;
            par_q    <= head_par;
            par_en_q <= PAR_EN;
            stop2_q  <= STOP2;
            div_m1_q <= baud_m1;
         end
      end
   end

   assign TX_OUT = tx_q;
   assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Scoreboard bench for uart_tx_cfg: each accepted word queues its expected
// per-clock line levels; a negedge monitor pops and compares while busy.
module tb_uart_tx_cfg;

   logic        CLK;
   logic        RST;
   logic [7:0]  P_DATA;
   logic        Data_Valid;
   logic        Data_Ready;
   logic        PAR_EN;
   logic        PAR_TYP;
   logic        STOP2;
   logic [15:0] BAUD_DIV;
   logic        TX_OUT;
   logic        busy;
   logic [2:0]  fifo_count;

   int   n_cmp = 0;
   int   n_bad = 0;
   logic exp_q[$];
   bit   mon_en = 1'b0;
   logic mon_e;

   uart_tx_cfg #(.DATA_WD(8), .DEPTH(4), .DIV_WD(16)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .P_DATA     (P_DATA),
      .Data_Valid (Data_Valid),
      .Data_Ready (Data_Ready),
      .PAR_EN     (PAR_EN),
      .PAR_TYP    (PAR_TYP),
      .STOP2      (STOP2),
      .BAUD_DIV   (BAUD_DIV),
      .TX_OUT     (TX_OUT),
      .busy       (busy),
      .fifo_count (fifo_count)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every clock the line is either part of a queued frame (busy)
   // or idle-high.
   always @(negedge CLK) begin
      if (mon_en) begin
         if (busy) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL tx_extra: got busy=1 TX_OUT=%0b, want no frame in flight (t=%0t)", TX_OUT, $time);
            end else begin
               mon_e = exp_q.pop_front();
               chk("tx_bit", {31'b0, TX_OUT}, {31'b0, mon_e});
            end
         end else begin
            chk("tx_idle", {31'b0, TX_OUT}, 32'd1);
         end
      end
   end

   // frame holds the hand-computed bits in transmission order, first bit
   // leftmost; each bit is expected for div clocks.
   task automatic push_word(input logic [7:0] d, input logic [15:0] frame,
                            input int nbits, input int div);
      int t = 0;
      P_DATA     = d;
      Data_Valid = 1'b1;
      while (!Data_Ready && t < 2000) begin
         @(negedge CLK);
         t++;
      end
      if (!Data_Ready) begin
         n_cmp++;
         n_bad++;
         $display("FAIL push_timeout: got Data_Ready=0 for word 0x%0h, want 1", d);
         Data_Valid = 1'b0;
         return;
      end
      @(posedge CLK);
      for (int k = 0; k < nbits; k++) begin
         for (int r = 0; r < div; r++) begin
            exp_q.push_back(frame[nbits-1-k]);
         end
      end
      @(negedge CLK);
      Data_Valid = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int t = 0;
      while (!(busy == 1'b0 && fifo_count == 3'd0 && exp_q.size() == 0) && t < 3000) begin
         @(negedge CLK);
         t++;
      end
      chk({name, "_drain"}, exp_q.size(), 32'd0);
      chk({name, "_busy"}, {31'b0, busy}, 32'd0);
   endtask

   initial begin
      RST        = 1'b0;
      P_DATA     = 8'h00;
      Data_Valid = 1'b0;
      PAR_EN     = 1'b0;
      PAR_TYP    = 1'b0;
      STOP2      = 1'b0;
      BAUD_DIV   = 16'd1;

      // Reset state
      repeat (3) @(negedge CLK);
      chk("rst_tx",    {31'b0, TX_OUT},     32'd1);
      chk("rst_busy",  {31'b0, busy},       32'd0);
      chk("rst_count", {29'b0, fifo_count}, 32'd0);
      chk("rst_ready", {31'b0, Data_Ready}, 32'd1);
      RST    = 1'b1;
      mon_en = 1'b1;
      @(negedge CLK);

      // 1: no parity, one stop, 0xAA -> 0,0,1,0,1,0,1,0,1,1
      push_word(8'hAA, 16'(10'b0010101011), 10, 1);
      chk("s1_lat_count", {29'b0, fifo_count}, 32'd1);
      chk("s1_lat_busy0", {31'b0, busy},       32'd0);
      @(negedge CLK);
      chk("s1_lat_busy1", {31'b0, busy},       32'd1);
      chk("s1_lat_tx0",   {31'b0, TX_OUT},     32'd0);
      chk("s1_lat_pop",   {29'b0, fifo_count}, 32'd0);
      wait_idle("s1");

      // 2: even parity, 0xBA (five ones) -> parity 1
      PAR_EN = 1'b1; PAR_TYP = 1'b0;
      push_word(8'hBA, 16'(11'b0_01011101_1_1), 11, 1);
      wait_idle("s2");

      // 3: odd parity, two stops, 0xA6 (four ones) -> parity 1; config
      // changes during DATA must not alter the 12-clock frame
      PAR_TYP = 1'b1; STOP2 = 1'b1;
      push_word(8'hA6, 16'(12'b0_01100101_1_1_1), 12, 1);
      @(negedge CLK);
      @(negedge CLK);
      chk("s3_busy_mid", {31'b0, busy}, 32'd1);
      STOP2   = 1'b0;
      PAR_TYP = 1'b0;
      wait_idle("s3");

      // 4: divisor 16, six words back-to-back, FIFO fills
      PAR_EN = 1'b0; STOP2 = 1'b0; BAUD_DIV = 16'd16;
      push_word(8'h01, 16'(10'b0_10000000_1), 10, 16);
      push_word(8'h80, 16'(10'b0_00000001_1), 10, 16);
      push_word(8'hFF, 16'(10'b0_11111111_1), 10, 16);
      push_word(8'h00, 16'(10'b0_00000000_1), 10, 16);
      push_word(8'h5A, 16'(10'b0_01011010_1), 10, 16);
      chk("s4_full_count", {29'b0, fifo_count}, 32'd4);
      chk("s4_full_ready", {31'b0, Data_Ready}, 32'd0);
      push_word(8'hC3, 16'(10'b0_11000011_1), 10, 16);
      wait_idle("s4");

      // 5: divisor 0 acts as 1; even parity of 0x3C (four ones) is 0
      BAUD_DIV = 16'd0; PAR_EN = 1'b1; PAR_TYP = 1'b0;
      push_word(8'h3C, 16'(11'b0_00111100_0_1), 11, 1);
      wait_idle("s5");

      // 6: reset during DATA with two words queued
      BAUD_DIV = 16'd1; PAR_EN = 1'b0;
      push_word(8'h11, 16'(10'b0_10001000_1), 10, 1);
      push_word(8'h22, 16'(10'b0_01000100_1), 10, 1);
      push_word(8'h33, 16'(10'b0_11001100_1), 10, 1);
      chk("s6_pre_count", {29'b0, fifo_count}, 32'd2);
      chk("s6_pre_busy",  {31'b0, busy},       32'd1);
      RST = 1'b0;
      @(posedge CLK);
      exp_q.delete();
      @(negedge CLK);
      chk("s6_rst_tx",    {31'b0, TX_OUT},     32'd1);
      chk("s6_rst_busy",  {31'b0, busy},       32'd0);
      chk("s6_rst_count", {29'b0, fifo_count}, 32'd0);
      chk("s6_rst_ready", {31'b0, Data_Ready}, 32'd1);
      RST = 1'b1;
      @(negedge CLK);
      push_word(8'h96, 16'(10'b0_01101001_1), 10, 1);
      wait_idle("s6");

      repeat (3) @(negedge CLK);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
